// File: rtl/key_action_pkg.sv
// key_action_pkg: keycodes, DAS channel state type and counter width shared by
// key_action_gen and das_channel.
package key_action_pkg;

    localparam int CNT_W = 6;

    localparam logic [7:0] KEY_LEFT   = 8'h50;
    localparam logic [7:0] KEY_RIGHT  = 8'h4F;
    localparam logic [7:0] KEY_DOWN   = 8'h51;
    localparam logic [7:0] KEY_ROTATE = 8'h52;
    localparam logic [7:0] KEY_HARD   = 8'h2C;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        DELAY,
        REPEAT
    } chan_state_e;

    // A key is held if any of the four 8-bit slots carries its code.
    function automatic logic key_held(input logic [31:0] keycode, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keycode[8*i +: 8] == code) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/das_channel.sv
// das_channel: press-edge pulse plus frame-paced delayed auto-repeat for one key.
// FIRST_DELAY = 0 skips DELAY and repeats every REPEAT_RATE frames from the press.
module das_channel
    import key_action_pkg::*;
#(
    parameter int FIRST_DELAY = 10,
    parameter int REPEAT_RATE = 2,
    parameter bit REPEAT_EN   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic held,
    input  logic enable,
    input  logic frame_tick,
    output logic pulse
);

    localparam logic [CNT_W-1:0] LOAD_FIRST =
        CNT_W'((FIRST_DELAY == 0) ? REPEAT_RATE : FIRST_DELAY);
    localparam logic [CNT_W-1:0] LOAD_RATE  = CNT_W'(REPEAT_RATE);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;
    logic             pulse_q, pulse_d;
    logic             fire;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        held_d  = held;
        fire    = 1'b0;
        if (!held) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!held_q) begin
                        fire    = 1'b1;
                        state_d = FIRE;
                        cnt_d   = LOAD_FIRST;
                    end
                end
                FIRE, DELAY, REPEAT: begin
                    if (state_q == FIRE) state_d = (FIRST_DELAY == 0) ? REPEAT : DELAY;
                    // Expiry at 1 (or a stray 0) reloads instead of wrapping the counter.
                    if (REPEAT_EN && frame_tick) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            fire    = 1'b1;
                            cnt_d   = LOAD_RATE;
                            state_d = REPEAT;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // enable only masks the pulse; the repeat cadence keeps running.
        pulse_d = fire & enable;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/key_action_gen.sv
// key_action_gen: HID keycode word -> one-cycle Tetris action pulses with frame-paced repeat.
// Define KEY_ACTION_DAS_EN for lateral auto-repeat; otherwise left/right fire on press only.
module key_action_gen
    import key_action_pkg::*;
#(
    parameter int DAS_DELAY = 10,
    parameter int DAS_RATE  = 2,
    parameter int SOFT_RATE = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] keycode,
    input  logic        frame_clk,
    output logic        move_left,
    output logic        move_right,
    output logic        soft_drop,
    output logic        rotate,
    output logic        hard_drop,
    output logic        frame_tick
);

`ifdef KEY_ACTION_DAS_EN
    localparam bit LATERAL_REPEAT = 1'b1;
`else
    localparam bit LATERAL_REPEAT = 1'b0;
`endif

    logic held_left, held_right, held_down, held_rot, held_hard;
    logic fsync1_q, fsync1_d, fsync2_q, fsync2_d, fprev_q, fprev_d;
    logic frame_tick_q, frame_tick_d;
    logic rot_prev_q, rot_prev_d, hard_prev_q, hard_prev_d;
    logic rotate_q, rotate_d, hard_drop_q, hard_drop_d;

    always_comb begin
        held_left    = key_held(keycode, KEY_LEFT);
        held_right   = key_held(keycode, KEY_RIGHT);
        held_down    = key_held(keycode, KEY_DOWN);
        held_rot     = key_held(keycode, KEY_ROTATE);
        held_hard    = key_held(keycode, KEY_HARD);
        fsync1_d     = frame_clk;
        fsync2_d     = fsync1_q;
        fprev_d      = fsync2_q;
        frame_tick_d = fsync2_q & ~fprev_q;
        rot_prev_d   = held_rot;
        hard_prev_d  = held_hard;
        rotate_d     = held_rot & ~rot_prev_q;
        hard_drop_d  = held_hard & ~hard_prev_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsync1_q     <= 1'b0;
            fsync2_q     <= 1'b0;
            fprev_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            rot_prev_q   <= 1'b0;
            hard_prev_q  <= 1'b0;
            rotate_q     <= 1'b0;
            hard_drop_q  <= 1'b0;
        end else begin
            fsync1_q     <= fsync1_d;
            fsync2_q     <= fsync2_d;
            fprev_q      <= fprev_d;
            frame_tick_q <= frame_tick_d;
            rot_prev_q   <= rot_prev_d;
            hard_prev_q  <= hard_prev_d;
            rotate_q     <= rotate_d;
            hard_drop_q  <= hard_drop_d;
        end
    end

    // A left+right chord holds both channels idle; releasing one looks like a fresh press.
    das_channel #(
        .FIRST_DELAY(DAS_DELAY), .REPEAT_RATE(DAS_RATE), .REPEAT_EN(LATERAL_REPEAT)
    ) u_left (
        .clk(Clk), .reset(Reset), .held(held_left & ~held_right), .enable(1'b1),
        .frame_tick(frame_tick_q), .pulse(move_left)
    );

    das_channel #(
        .FIRST_DELAY(DAS_DELAY), .REPEAT_RATE(DAS_RATE), .REPEAT_EN(LATERAL_REPEAT)
    ) u_right (
        .clk(Clk), .reset(Reset), .held(held_right & ~held_left), .enable(1'b1),
        .frame_tick(frame_tick_q), .pulse(move_right)
    );

    das_channel #(
        .FIRST_DELAY(0), .REPEAT_RATE(SOFT_RATE), .REPEAT_EN(1'b1)
    ) u_soft (
        .clk(Clk), .reset(Reset), .held(held_down), .enable(~hard_drop_d),
        .frame_tick(frame_tick_q), .pulse(soft_drop)
    );

    assign rotate     = rotate_q;
    assign hard_drop  = hard_drop_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_key_action_gen.sv
// tb_key_action_gen: directed scenarios plus random keycode/frame traffic, checked every
// cycle against a tick-counting reference model.
module tb_key_action_gen;
    import key_action_pkg::*;

    localparam int DD = 10;
    localparam int DR = 2;
    localparam int SR = 3;
`ifdef KEY_ACTION_DAS_EN
    localparam bit DAS_ON = 1'b1;
`else
    localparam bit DAS_ON = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] keycode;
    logic        frame_clk;
    logic        move_left, move_right, soft_drop, rotate, hard_drop, frame_tick;

    key_action_gen #(.DAS_DELAY(DD), .DAS_RATE(DR), .SOFT_RATE(SR)) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_clk(frame_clk),
        .move_left(move_left), .move_right(move_right), .soft_drop(soft_drop),
        .rotate(rotate), .hard_drop(hard_drop), .frame_tick(frame_tick)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // Model: per channel, frames counted since the press; repeats fall out of arithmetic.
    bit m_prev [5];   // left, right, down, rotate, hard
    int m_k    [3];
    bit fh     [4];   // frame_clk samples, newest first
    bit e      [6];   // expected left, right, soft, rotate, hard, frame_tick
    int n      [5];   // observed pulse counts

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit has(input logic [31:0] kc, input logic [7:0] code);
        bit h;
        h = 1'b0;
        for (int s = 0; s < 4; s++) if (kc[8*s +: 8] == code) h = 1'b1;
        return h;
    endfunction

    function automatic bit repeat_due(input int ch, input int k);
        if (ch == 2) return (k > 0) && (k % SR == 0);
        return DAS_ON && ((k == DD) || ((k > DD) && ((k - DD) % DR == 0)));
    endfunction

    task automatic model_edge();
        bit eff [3];
        bit tick_in, hp, rot, hard, p;
        if (Reset) begin
            for (int i = 0; i < 5; i++) m_prev[i] = 1'b0;
            for (int i = 0; i < 3; i++) m_k[i] = 0;
            for (int i = 0; i < 4; i++) fh[i] = 1'b0;
            for (int i = 0; i < 6; i++) e[i] = 1'b0;
            return;
        end
        eff[0]  = has(keycode, KEY_LEFT) && !has(keycode, KEY_RIGHT);
        eff[1]  = has(keycode, KEY_RIGHT) && !has(keycode, KEY_LEFT);
        eff[2]  = has(keycode, KEY_DOWN);
        rot     = has(keycode, KEY_ROTATE);
        hard    = has(keycode, KEY_HARD);
        tick_in = e[5];
        hp      = hard && !m_prev[4];
        for (int ch = 0; ch < 3; ch++) begin
            p = 1'b0;
            if (eff[ch] && !m_prev[ch]) begin
                p = 1'b1;
                m_k[ch] = 0;
            end else if (eff[ch] && tick_in) begin
                m_k[ch]++;
                p = repeat_due(ch, m_k[ch]);
            end
            m_prev[ch] = eff[ch];
            e[ch] = p;
        end
        if (hp) e[2] = 1'b0;
        e[3] = rot && !m_prev[3];
        e[4] = hp;
        m_prev[3] = rot;
        m_prev[4] = hard;
        for (int i = 3; i > 0; i--) fh[i] = fh[i-1];
        fh[0] = frame_clk;
        e[5] = fh[2] && !fh[3];
    endtask

    task automatic step(input logic [31:0] kc, input logic fc, input logic rst);
        keycode   = kc;
        frame_clk = fc;
        Reset     = rst;
        @(posedge Clk);
        model_edge();
        #1;
        check("move_left",  32'(move_left),  32'(e[0]));
        check("move_right", 32'(move_right), 32'(e[1]));
        check("soft_drop",  32'(soft_drop),  32'(e[2]));
        check("rotate",     32'(rotate),     32'(e[3]));
        check("hard_drop",  32'(hard_drop),  32'(e[4]));
        check("frame_tick", 32'(frame_tick), 32'(e[5]));
        n[0] += int'(move_left);
        n[1] += int'(move_right);
        n[2] += int'(soft_drop);
        n[3] += int'(rotate);
        n[4] += int'(hard_drop);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 5; i++) n[i] = 0;
    endtask

    // One frame = 8 cycles (frame_clk high for 4); keycode switches to kc_hi at cycle sw.
    task automatic frame_one(input logic [31:0] kc_lo, input logic [31:0] kc_hi, input int sw);
        for (int j = 0; j < 8; j++) step((j < sw) ? kc_lo : kc_hi, j < 4, 1'b0);
    endtask

    task automatic frames(input logic [31:0] kc, input int cnt);
        for (int f = 0; f < cnt; f++) frame_one(kc, kc, 0);
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] kc;
        logic [7:0]  pool [10];
        logic        fc;
        int          fc_left, kc_left;

        pool = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h50, 8'h4F, 8'h51, 8'h52, 8'h2C, 8'h04};
        keycode = '0; frame_clk = 1'b0; Reset = 1'b1;
        for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 1'b1);
        idle(2);

        // Tap left for 5 cycles, no frames.
        clear_counts();
        for (int i = 0; i < 5; i++) step(32'h0000_0050, 1'b0, 1'b0);
        idle(3);
        check("tap_left_pulses", 32'(n[0]), 32'd1);
        check("tap_other_pulses", 32'(n[1] + n[2] + n[3] + n[4]), 32'd0);

        // Hold right across 14 frames.
        clear_counts();
        frames(32'h0000_004F, 14);
        idle(3);
        check("das_right_pulses", 32'(n[1]), DAS_ON ? 32'd4 : 32'd1);

        // Left+right chord for 20 frames, then drop right.
        clear_counts();
        frames(32'h4F00_0050, 20);
        check("chord_lateral_pulses", 32'(n[0] + n[1]), 32'd0);
        step(32'h0000_0050, 1'b0, 1'b0);
        check("chord_release_left", 32'(move_left), 32'd1);
        idle(3);

        // Space + up together, held.
        clear_counts();
        for (int i = 0; i < 10; i++) step(32'h0000_2C52, 1'b0, 1'b0);
        idle(2);
        check("chord_rotate_pulses", 32'(n[3]), 32'd1);
        check("chord_hard_pulses", 32'(n[4]), 32'd1);

        // Hold down 9 frames; space lands on the tick-6 soft pulse cycle and suppresses it.
        clear_counts();
        step(32'h0000_0051, 1'b0, 1'b0);
        check("soft_press", 32'(soft_drop), 32'd1);
        frames(32'h0000_0051, 5);
        frame_one(32'h0000_0051, 32'h0000_2C51, 3);
        frames(32'h0000_2C51, 3);
        idle(3);
        check("soft_pulses", 32'(n[2]), 32'd3);
        check("soft_hard_pulses", 32'(n[4]), 32'd1);

        // Reset while left sits in DELAY.
        step(32'h0000_0050, 1'b0, 1'b0);
        frames(32'h0000_0050, 3);
        step(32'h0000_0050, 1'b0, 1'b1);
        check("reset_left_low", 32'(move_left), 32'd0);
        clear_counts();
        step(32'h0000_0050, 1'b0, 1'b0);
        check("reset_fresh_press", 32'(move_left), 32'd1);
        clear_counts();
        frames(32'h0000_0050, 10);
        check("reset_das_restart", 32'(n[0]), DAS_ON ? 32'd1 : 32'd0);
        idle(3);

        // Random traffic.
        fc = 1'b0; fc_left = 4; kc = '0; kc_left = 1;
        for (int c = 0; c < 4000; c++) begin
            if (fc_left == 0) begin
                fc = ~fc;
                fc_left = $urandom_range(3, 8);
            end
            fc_left--;
            if (kc_left == 0) begin
                for (int s = 0; s < 4; s++) kc[8*s +: 8] = pool[$urandom_range(0, 9)];
                kc_left = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 250)
                                                      : $urandom_range(1, 30);
            end
            kc_left--;
            step(kc, fc, $urandom_range(0, 799) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
